// File: rtl/cache_pkg.sv
// Shared cache/coherence-bus definitions: arbiter state encoding and index-width helper.
package cache_pkg;

    typedef enum logic [0:0] {
        e_arb_idle = 1'b0,
        e_arb_busy = 1'b1
    } arb_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping, via a doubled-vector scan.
module rr_pick
    import cache_pkg::*;
#(
    parameter int unsigned  width_p     = 4,
    localparam int unsigned id_width_lp = id_width(width_p)
) (
    input  logic [width_p-1:0]     req,
    input  logic [id_width_lp-1:0] ptr,
    output logic [width_p-1:0]     gnt,
    output logic [id_width_lp-1:0] idx,
    output logic                   any_v
);

    localparam int unsigned sel_width_lp = $clog2(2 * width_p);

    logic [2*width_p-1:0] dbl;
    int unsigned          off;
    int unsigned          pos;
    logic                 found;

    assign dbl   = {req, req};
    assign any_v = |req;

    // Scanning the doubled vector upward from ptr covers the wrap without a modulo per bit.
    always_comb begin
        off   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < width_p; i++) begin
            if (dbl[sel_width_lp'(32'(ptr) + i)] && !found) begin
                off   = i;
                found = 1'b1;
            end
        end
        pos = (32'(ptr) + off) % width_p;
        idx = id_width_lp'(pos);
        gnt = any_v ? (width_p'(1) << idx) : '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin coherence-bus arbiter with single-cycle yumi, transaction ownership and timed lock.
module bus_arbiter
    import cache_pkg::*;
#(
    parameter int unsigned  num_caches_p   = 4,
    parameter int unsigned  lock_timeout_p = 8,
    localparam int unsigned id_width_lp    = id_width(num_caches_p)
) (
    input  logic                    clk_i,
    input  logic                    nreset_i,
    input  logic [num_caches_p-1:0] cb_valid_i,
    output logic [num_caches_p-1:0] cb_yumi_o,
    output logic                    grant_v_o,
    output logic [id_width_lp-1:0]  grant_id_o,
    input  logic                    tx_done_i,
    input  logic                    lock_i,
    output logic                    locked_o
);

    localparam int unsigned cnt_width_lp = (lock_timeout_p > 1) ? $clog2(lock_timeout_p) : 1;
    localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(lock_timeout_p - 1);
    localparam logic [id_width_lp-1:0]  id_last_lp  = id_width_lp'(num_caches_p - 1);

    arb_state_t                state_r;
    logic [id_width_lp-1:0]    ptr_r;
    logic [id_width_lp-1:0]    owner_r;
    logic                      lock_r;
    logic [id_width_lp-1:0]    lock_id_r;
    logic [cnt_width_lp-1:0]   lock_cnt_r;

    logic [num_caches_p-1:0]   eligible;
    logic [num_caches_p-1:0]   pick_gnt;
    logic [id_width_lp-1:0]    pick_idx;
    logic                      pick_any;
    logic                      idle_go;
    logic [id_width_lp-1:0]    ptr_next;

    // While a lock is held only the locked cache may win.
    assign eligible = lock_r ? (cb_valid_i & (num_caches_p'(1) << lock_id_r)) : cb_valid_i;

    rr_pick #(
        .width_p (num_caches_p)
    ) u_pick (
        .req   (eligible),
        .ptr   (ptr_r),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any_v (pick_any)
    );

    assign idle_go  = (state_r == e_arb_idle) && nreset_i && pick_any;
    assign ptr_next = (owner_r == id_last_lp) ? '0 : owner_r + id_width_lp'(1);

    assign cb_yumi_o  = idle_go ? pick_gnt : '0;
    assign grant_v_o  = (state_r == e_arb_busy);
    assign grant_id_o = grant_v_o ? owner_r : (idle_go ? pick_idx : '0);
    assign locked_o   = lock_r;

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state_r    <= e_arb_idle;
            ptr_r      <= '0;
            owner_r    <= '0;
            lock_r     <= 1'b0;
            lock_id_r  <= '0;
            lock_cnt_r <= '0;
        end else begin
            case (state_r)
                e_arb_idle: begin
                    if (idle_go) begin
                        state_r    <= e_arb_busy;
                        owner_r    <= pick_idx;
                        lock_r     <= 1'b0;
                        lock_cnt_r <= '0;
                    end else if (lock_r) begin
                        // Locked cache absent: give up after lock_timeout_p idle cycles.
                        if (lock_cnt_r == cnt_last_lp) begin
                            lock_r     <= 1'b0;
                            lock_cnt_r <= '0;
                        end else begin
                            lock_cnt_r <= lock_cnt_r + cnt_width_lp'(1);
                        end
                    end
                end
                e_arb_busy: begin
                    if (tx_done_i) begin
                        state_r <= e_arb_idle;
                        ptr_r   <= ptr_next;
                        if (lock_i) begin
                            lock_r     <= 1'b1;
                            lock_id_r  <= owner_r;
                            lock_cnt_r <= '0;
                        end
                    end
                end
                default: state_r <= e_arb_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: round-robin order, wrap, busy masking, lock hold/timeout, reset.
module tb_bus_arbiter;

    localparam int max_wait_lp = 20;

    logic       clk_i;
    logic       nreset_i;
    logic [3:0] cb_valid_i;
    logic [3:0] cb_yumi_o;
    logic       grant_v_o;
    logic [1:0] grant_id_o;
    logic       tx_done_i;
    logic       lock_i;
    logic       locked_o;

    int         total;
    int         bad;
    bit         mon_en;
    logic [1:0] sb[$];
    logic [1:0] ptr_m;
    logic [1:0] lid_m;
    logic       lock_m;

    bus_arbiter #(
        .num_caches_p   (4),
        .lock_timeout_p (8)
    ) dut (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .cb_valid_i (cb_valid_i),
        .cb_yumi_o  (cb_yumi_o),
        .grant_v_o  (grant_v_o),
        .grant_id_o (grant_id_o),
        .tx_done_i  (tx_done_i),
        .lock_i     (lock_i),
        .locked_o   (locked_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Protocol properties checked every cycle once out of the initial reset.
    always @(negedge clk_i) begin
        if (mon_en) begin
            total = total + 1;
            if (!$onehot0(cb_yumi_o)) begin
                bad = bad + 1;
                $display("FAIL yumi_onehot0: got=%b", cb_yumi_o);
            end
            total = total + 1;
            if ((cb_yumi_o & ~cb_valid_i) !== 4'b0000) begin
                bad = bad + 1;
                $display("FAIL yumi_without_valid: yumi=%b valid=%b", cb_yumi_o, cb_valid_i);
            end
            total = total + 1;
            if (grant_v_o === 1'b1 && cb_yumi_o !== 4'b0000) begin
                bad = bad + 1;
                $display("FAIL yumi_while_busy: yumi=%b exp=0000", cb_yumi_o);
            end
        end
    end

    function automatic logic [1:0] model_pick(input logic [3:0] v, input logic [1:0] p,
                                              input logic lk, input logic [1:0] lid);
        logic [3:0] e;
        e = v;
        if (lk) e = v & (4'b0001 << lid);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (int'(p) + k) % 4;
            if (e[j]) return 2'(j);
        end
        return 2'd0;
    endfunction

    // Waits (bounded) for a yumi; returns at posedge+1 of the cycle after it.
    task automatic wait_yumi(input int max_cyc, output logic [3:0] y, output logic [1:0] id,
                             output int waited);
        y      = '0;
        id     = '0;
        waited = max_cyc;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk_i);
            if (cb_yumi_o !== 4'b0000) begin
                y      = cb_yumi_o;
                id     = grant_id_o;
                waited = c;
                @(posedge clk_i); #1;
                return;
            end
            @(posedge clk_i); #1;
        end
    endtask

    // One full transaction: grant, busy_n owned cycles, tx_done on the last one.
    task automatic serve(input logic [3:0] v, input logic [3:0] v_busy, input int busy_n,
                         input logic lk, input int exp_w);
        logic [3:0] y;
        logic [1:0] id;
        logic [1:0] exp;
        int         w;
        cb_valid_i = v;
        sb.push_back(model_pick(v, ptr_m, lock_m, lid_m));
        wait_yumi(max_wait_lp, y, id, w);
        exp = sb.pop_front();
        total = total + 1;
        if (w !== exp_w) begin
            bad = bad + 1;
            $display("FAIL yumi_latency: got=%0d exp=%0d", w, exp_w);
        end
        total = total + 1;
        if (id !== exp) begin
            bad = bad + 1;
            $display("FAIL grant_id_at_yumi: got=%0d exp=%0d", id, exp);
        end
        total = total + 1;
        if (y !== (4'b0001 << exp)) begin
            bad = bad + 1;
            $display("FAIL yumi_vector: got=%b exp=%b", y, 4'b0001 << exp);
        end
        lock_m     = 1'b0;
        cb_valid_i = v_busy;
        for (int i = 0; i < busy_n; i++) begin
            if (i == busy_n - 1) begin
                tx_done_i = 1'b1;
                lock_i    = lk;
            end
            @(negedge clk_i);
            total = total + 1;
            if (grant_v_o !== 1'b1 || grant_id_o !== exp) begin
                bad = bad + 1;
                $display("FAIL busy_owner: got v=%b id=%0d exp v=1 id=%0d", grant_v_o, grant_id_o, exp);
            end
            total = total + 1;
            if (cb_yumi_o !== 4'b0000) begin
                bad = bad + 1;
                $display("FAIL busy_no_yumi: got=%b exp=0000", cb_yumi_o);
            end
            @(posedge clk_i); #1;
        end
        tx_done_i = 1'b0;
        lock_i    = 1'b0;
        total = total + 1;
        if (grant_v_o !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL grant_v_after_done: got=%b exp=0", grant_v_o);
        end
        total = total + 1;
        if (locked_o !== lk) begin
            bad = bad + 1;
            $display("FAIL locked_after_done: got=%b exp=%b", locked_o, lk);
        end
        ptr_m = 2'(exp + 1);
        if (lk) begin
            lock_m = 1'b1;
            lid_m  = exp;
        end
    endtask

    task automatic test_reset();
        nreset_i   = 1'b0;
        cb_valid_i = 4'b0000;
        tx_done_i  = 1'b0;
        lock_i     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        mon_en = 1'b1;
        @(negedge clk_i);
        total = total + 1;
        if (grant_v_o !== 1'b0 || cb_yumi_o !== 4'b0000 || grant_id_o !== 2'd0 || locked_o !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs: got v=%b yumi=%b id=%0d lk=%b exp all 0",
                     grant_v_o, cb_yumi_o, grant_id_o, locked_o);
        end
        @(posedge clk_i); #1;
        nreset_i = 1'b1;
        ptr_m    = 2'd0;
        lock_m   = 1'b0;
        lid_m    = 2'd0;
        @(negedge clk_i);
        total = total + 1;
        if (grant_v_o !== 1'b0 || cb_yumi_o !== 4'b0000) begin
            bad = bad + 1;
            $display("FAIL idle_no_request: got v=%b yumi=%b exp v=0 yumi=0000", grant_v_o, cb_yumi_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_round_robin();
        for (int g = 0; g < 5; g++) serve(4'b1111, 4'b1111, 3, 1'b0, 0);
    endtask

    task automatic test_wrap();
        serve(4'b0010, 4'b0010, 3, 1'b0, 0);
        serve(4'b0011, 4'b0011, 3, 1'b0, 0);
        serve(4'b0011, 4'b0000, 3, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        serve(4'b0100, 4'b0110, 4, 1'b0, 0);
        serve(4'b0110, 4'b0000, 3, 1'b0, 0);
    endtask

    task automatic test_lock_present();
        serve(4'b1000, 4'b0000, 3, 1'b1, 0);
        cb_valid_i = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            total = total + 1;
            if (locked_o !== 1'b1 || cb_yumi_o !== 4'b0000) begin
                bad = bad + 1;
                $display("FAIL lock_hold: got lk=%b yumi=%b exp lk=1 yumi=0000", locked_o, cb_yumi_o);
            end
            @(posedge clk_i); #1;
        end
        serve(4'b1001, 4'b0000, 3, 1'b0, 0);
    endtask

    task automatic test_lock_timeout();
        serve(4'b0010, 4'b0000, 3, 1'b1, 0);
        cb_valid_i = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            total = total + 1;
            if (locked_o !== 1'b1 || cb_yumi_o !== 4'b0000) begin
                bad = bad + 1;
                $display("FAIL lock_timeout_hold: cycle=%0d got lk=%b yumi=%b exp lk=1 yumi=0000",
                         k, locked_o, cb_yumi_o);
            end
            @(posedge clk_i); #1;
        end
        lock_m = 1'b0;
        total = total + 1;
        if (locked_o !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL lock_timeout_drop: got=%b exp=0", locked_o);
        end
        serve(4'b0100, 4'b0000, 3, 1'b0, 0);
    endtask

    task automatic test_reset_mid_busy();
        logic [3:0] y;
        logic [1:0] id;
        logic [1:0] exp;
        int         w;
        cb_valid_i = 4'b0100;
        sb.push_back(model_pick(cb_valid_i, ptr_m, lock_m, lid_m));
        wait_yumi(max_wait_lp, y, id, w);
        exp = sb.pop_front();
        total = total + 1;
        if (id !== exp || w !== 0) begin
            bad = bad + 1;
            $display("FAIL pre_reset_grant: got id=%0d wait=%0d exp id=%0d wait=0", id, w, exp);
        end
        cb_valid_i = 4'b1111;
        nreset_i   = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk_i);
            total = total + 1;
            if (cb_yumi_o !== 4'b0000) begin
                bad = bad + 1;
                $display("FAIL reset_no_yumi: cycle=%0d got=%b exp=0000", r, cb_yumi_o);
            end
            if (r > 0) begin
                total = total + 1;
                if (grant_v_o !== 1'b0) begin
                    bad = bad + 1;
                    $display("FAIL reset_grant_v: cycle=%0d got=%b exp=0", r, grant_v_o);
                end
            end
            @(posedge clk_i); #1;
        end
        nreset_i = 1'b1;
        ptr_m    = 2'd0;
        lock_m   = 1'b0;
        serve(4'b1111, 4'b0000, 3, 1'b0, 0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        test_reset();
        test_round_robin();
        test_wrap();
        test_back_to_back();
        test_lock_present();
        test_lock_timeout();
        test_reset_mid_busy();
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain: got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
